// File: rtl/apb_keyed_lock_regfile.sv
// APB register file with NUM_REGS lockable control registers. Lock bits can
// only be cleared after a two-word key sequence (MAGIC_KEY, ~MAGIC_KEY) opens
// an unlock window that expires after UNLOCK_TIMEOUT cycles per step.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   paddr..pwdata     APB requester inputs
//   prdata, pready, pslverr   APB completer responses (pready tied high)
//   status_in         hardware status, registered into the STATUS register
//   ctrl_out          concatenated control registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lock_out          per-register lock bits
//   unlock_open       high while the unlock window is open
//   key_fail          one-cycle pulse on a bad key or a step timeout
module apb_keyed_lock_regfile #(
    parameter int unsigned              ADDR_WIDTH     = 8,
    parameter int unsigned              DATA_WIDTH     = 32,
    parameter int unsigned              NUM_REGS       = 8,
    parameter logic [DATA_WIDTH-1:0]    MAGIC_KEY      = DATA_WIDTH'(32'hDEADBEEF),
    parameter int unsigned              UNLOCK_TIMEOUT = 64,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_REGS-1:0]            lock_out,
    output logic                           unlock_open,
    output logic                           key_fail
);

    localparam int unsigned IDX_W   = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W   = $clog2(UNLOCK_TIMEOUT + 1);
    localparam int unsigned KEY_IDX  = NUM_REGS;
    localparam int unsigned LOCK_IDX = NUM_REGS + 1;
    localparam int unsigned STAT_IDX = NUM_REGS + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        OPEN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            fail_cnt_q;
    logic                  fail_c;
    logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
    logic [NUM_REGS-1:0]   lock_q;
    logic [DATA_WIDTH-1:0] status_q;

    // Address decode on the word index; anything misaligned is unmapped.
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      idx32;
    logic             aligned, mapped, is_ctrl, is_key, is_lock, is_status;
    logic             access, wr_ok, key_wr, lock_wr, ctrl_locked_c;

    assign word_idx  = paddr[ADDR_WIDTH-1:2];
    assign idx32     = 32'(word_idx);
    assign aligned   = (paddr[1:0] == 2'b00);
    assign mapped    = aligned && (idx32 < NUM_REGS + 3);
    assign is_ctrl   = aligned && (idx32 < NUM_REGS);
    assign is_key    = aligned && (idx32 == KEY_IDX);
    assign is_lock   = aligned && (idx32 == LOCK_IDX);
    assign is_status = aligned && (idx32 == STAT_IDX);
    assign access    = psel && penable;

    // Lock bit of the addressed CTRL register.
    always_comb begin
        ctrl_locked_c = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (is_ctrl && (idx32 == 32'(i))) begin
                ctrl_locked_c = lock_q[i];
            end
        end
    end

    assign pslverr = access && (!mapped || (pwrite && (ctrl_locked_c || is_status)));
    assign wr_ok   = access && pwrite && !pslverr;
    assign key_wr  = wr_ok && is_key;
    assign lock_wr = wr_ok && is_lock;
    assign pready  = 1'b1;

    // Read mux, combinational during any selected read cycle.
    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (is_ctrl && (idx32 == 32'(i))) begin
                    prdata = ctrl_q[i];
                end
            end
            if (is_key) begin
                prdata[15:8] = fail_cnt_q;
                prdata[1:0]  = state_q;
            end
            if (is_lock)   prdata = DATA_WIDTH'(lock_q);
            if (is_status) prdata = status_q;
        end
    end

    // Key sequence state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Key sequence next state; APB writes take priority over expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_wr) begin
                    if (pwdata == MAGIC_KEY) begin
                        state_d = ARMED;
                        cnt_d   = CNT_W'(UNLOCK_TIMEOUT);
                    end else begin
                        fail_c = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (key_wr) begin
                    if (pwdata == ~MAGIC_KEY) begin
                        state_d = OPEN;
                        cnt_d   = CNT_W'(UNLOCK_TIMEOUT);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        fail_c  = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fail_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OPEN: begin
                if (key_wr || lock_wr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fail_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fail pulse and saturating fail counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_fail   <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            key_fail <= fail_c;
            if (fail_c && (fail_cnt_q != 8'hFF)) begin
                fail_cnt_q <= fail_cnt_q + 8'd1;
            end
        end
    end

    // Lock bits: set any time, cleared only from within the open window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else if (lock_wr) begin
            if (state_q == OPEN) lock_q <= pwdata[NUM_REGS-1:0];
            else                 lock_q <= lock_q | pwdata[NUM_REGS-1:0];
        end
    end

    // Control registers and status capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) ctrl_q[i] <= RESET_VALUE;
            status_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_ok && is_ctrl && (idx32 == 32'(i))) ctrl_q[i] <= pwdata;
            end
            status_q <= status_in;
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_ctrl_out
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end

    assign lock_out    = lock_q;
    assign unlock_open = (state_q == OPEN);

endmodule

// File: tb/tb_apb_keyed_lock_regfile.sv
// Randomised bench for apb_keyed_lock_regfile with an edge-level reference
// model that tracks the unlock window as an absolute deadline edge.
module tb_apb_keyed_lock_regfile;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned TO = 64;
    localparam logic [31:0] MK = 32'hDEADBEEF;
    localparam logic [7:0]  KEY_A  = 8'(N*4);
    localparam logic [7:0]  LOCK_A = 8'(N*4 + 4);
    localparam logic [7:0]  STAT_A = 8'(N*4 + 8);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0, status_in = '0;
    logic [DW-1:0] prdata;
    logic          pready, pslverr, unlock_open, key_fail;
    logic [N*DW-1:0] ctrl_out;
    logic [N-1:0]  lock_out;

    apb_keyed_lock_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(N),
        .MAGIC_KEY(MK), .UNLOCK_TIMEOUT(TO), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .status_in(status_in), .ctrl_out(ctrl_out),
        .lock_out(lock_out), .unlock_open(unlock_open), .key_fail(key_fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][31:0] ctrl;
        logic [N-1:0]       lock;
        logic [1:0]         phase;     // 0 idle, 1 armed, 2 open
        logic [31:0]        edge_n;
        logic [31:0]        deadline;  // edge number on which the window expires
        logic [7:0]         fcnt;
        logic               kfail;
        logic [31:0]        status;
    } model_t;

    model_t m;
    int n_checks = 0;
    int n_fail   = 0;
    int kf_seen  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge of the reference model.
    function automatic model_t step(model_t c, logic s, logic e, logic w,
                                    logic [7:0] a, logic [31:0] d, logic [31:0] st);
        model_t n = c;
        logic [31:0] ed = c.edge_n + 1;
        int  idx = int'(a >> 2);
        bit  wr  = s && e && w && (a[1:0] == 2'b00);
        bit  fail = 0;
        n.edge_n = ed;
        if (wr && idx == int'(N)) begin
            case (c.phase)
                2'd0: if (d == MK) begin n.phase = 1; n.deadline = ed + TO; end
                      else fail = 1;
                2'd1: if (d == ~MK) begin n.phase = 2; n.deadline = ed + TO; end
                      else begin n.phase = 0; fail = 1; end
                default: n.phase = 0;
            endcase
        end else if (wr && idx == int'(N) + 1 && c.phase == 2) begin
            n.lock  = d[N-1:0];
            n.phase = 0;
        end else if (c.phase != 0 && ed == c.deadline) begin
            n.phase = 0;
            fail = 1;
        end
        if (wr && idx == int'(N) + 1 && c.phase != 2) n.lock = c.lock | d[N-1:0];
        if (wr && idx < int'(N) && !c.lock[idx]) n.ctrl[idx] = d;
        n.status = st;
        n.kfail  = fail;
        if (fail && c.fcnt != 8'hFF) n.fcnt = c.fcnt + 8'd1;
        return n;
    endfunction

    function automatic logic [31:0] rd_exp(model_t c, logic [7:0] a);
        int idx = int'(a >> 2);
        if (a[1:0] != 2'b00)         return 32'h0;
        if (idx < int'(N))           return c.ctrl[idx];
        if (idx == int'(N))          return {16'h0, c.fcnt, 6'h0, c.phase};
        if (idx == int'(N) + 1)      return 32'(c.lock);
        if (idx == int'(N) + 2)      return c.status;
        return 32'h0;
    endfunction

    function automatic logic err_exp(model_t c, logic [7:0] a, logic w);
        int idx = int'(a >> 2);
        if (a[1:0] != 2'b00 || idx >= int'(N) + 3) return 1'b1;
        if (w && idx < int'(N) && c.lock[idx])     return 1'b1;
        if (w && idx == int'(N) + 2)               return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{ctrl: '0, lock: '0, phase: 2'd0, edge_n: '0, deadline: '0,
                   fcnt: '0, kfail: 1'b0, status: '0};
        end else begin
            m <= step(m, psel, penable, pwrite, paddr, pwdata, status_in);
        end
    end

    // Register-driven outputs compared every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("lock_out", 256'(lock_out), 256'(m.lock));
            check("ctrl_out", 256'(ctrl_out), 256'(m.ctrl));
            check("unlock_open", 256'(unlock_open), 256'(m.phase == 2'd2));
            check("key_fail", 256'(key_fail), 256'(m.kfail));
            if (key_fail) kf_seen <= kf_seen + 1;
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("wr_pslverr", 256'(pslverr), 256'(err_exp(m, a, 1'b1)));
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        check("rd_prdata", 256'(prdata), 256'(rd_exp(m, a)));
        check("rd_pslverr", 256'(pslverr), 256'(err_exp(m, a, 1'b0)));
        check("pready", 256'(pready), 256'(1'b1));
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        int kf0;
        #1 rst_n = 1'b0;
        idle(3);
        check("rst_ctrl", 256'(ctrl_out), 256'h0);
        check("rst_lock", 256'(lock_out), 256'h0);
        check("rst_open", 256'(unlock_open), 256'h0);
        check("rst_kfail", 256'(key_fail), 256'h0);
        check("rst_prdata", 256'(prdata), 256'h0);
        check("rst_pslverr", 256'(pslverr), 256'h0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < int'(N); i++) apb_read(8'(i*4), r);
        apb_read(LOCK_A, r);
        apb_read(KEY_A, r);
        check("key_after_rst", 256'(r), 256'h0);
        apb_read(8'(N*4 + 12), r);

        // Locked CTRL write is rejected.
        apb_write(8'd12, 32'hA5A5A5A5);
        apb_write(LOCK_A, 32'h08);
        apb_write(8'd12, 32'h12345678);
        check("ctrl3_locked", 256'(ctrl_out[3*DW +: DW]), 256'hA5A5A5A5);
        check("lock_08", 256'(lock_out), 256'h08);
        apb_write(LOCK_A, 32'h00);
        check("lock_kept_idle", 256'(lock_out), 256'h08);

        // Full unlock sequence.
        apb_write(KEY_A, MK);
        apb_write(KEY_A, ~MK);
        check("open_after_keys", 256'(unlock_open), 256'h1);
        apb_write(LOCK_A, 32'h00);
        check("lock_cleared", 256'(lock_out), 256'h0);
        check("closed_after_lock", 256'(unlock_open), 256'h0);
        apb_write(8'd12, 32'h12345678);
        check("ctrl3_unlocked", 256'(ctrl_out[3*DW +: DW]), 256'h12345678);

        // Step timeout in ARMED.
        kf0 = kf_seen;
        apb_write(KEY_A, MK);
        idle(70);
        check("timeout_pulses", 256'(kf_seen - kf0), 256'h1);
        apb_read(KEY_A, r);
        check("key_after_timeout", 256'(r), 256'h100);
        apb_write(KEY_A, 32'h11111111);
        apb_read(KEY_A, r);
        check("key_after_bad", 256'(r), 256'h200);

        // LOCK write landing on the expiry edge still clears.
        apb_write(LOCK_A, 32'hFF);
        kf0 = kf_seen;
        apb_write(KEY_A, MK);
        apb_write(KEY_A, ~MK);
        idle(TO - 2);
        apb_write(LOCK_A, 32'h00);
        idle(1);
        check("expiry_edge_clear", 256'(lock_out), 256'h0);
        check("expiry_edge_nofail", 256'(kf_seen - kf0), 256'h0);

        // One cycle later the window has already closed.
        apb_write(LOCK_A, 32'hFF);
        kf0 = kf_seen;
        apb_write(KEY_A, MK);
        apb_write(KEY_A, ~MK);
        idle(TO - 1);
        apb_write(LOCK_A, 32'h00);
        idle(1);
        check("late_no_clear", 256'(lock_out), 256'hFF);
        check("late_fail", 256'(kf_seen - kf0), 256'h1);

        // Asynchronous reset while ARMED.
        apb_write(KEY_A, MK);
        apb_read(KEY_A, r);
        check("armed_before_rst", 256'(r[1:0]), 256'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lock", 256'(lock_out), 256'h0);
        check("async_rst_ctrl", 256'(ctrl_out), 256'h0);
        check("async_rst_open", 256'(unlock_open), 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apb_read(KEY_A, r);
        check("key_after_async_rst", 256'(r), 256'h0);

        // Status capture and write protection.
        status_in = 32'hCAFEF00D;
        idle(1);
        apb_read(STAT_A, r);
        check("status_read", 256'(r), 256'hCAFEF00D);
        apb_write(STAT_A, 32'h0);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [7:0] a;
            status_in = $urandom;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    a = 8'($urandom_range(0, N-1) * 4);
                    if ($urandom_range(0, 9) == 0) a = a | 8'($urandom_range(1, 3));
                    apb_write(a, $urandom);
                end
                3: apb_write(LOCK_A, 32'($urandom_range(0, 255)));
                4: begin
                    apb_write(KEY_A, MK);
                    if ($urandom_range(0, 9) < 7) apb_write(KEY_A, ~MK);
                end
                5: apb_write(KEY_A, ($urandom_range(0, 3) == 0) ? MK : $urandom);
                6: apb_read(8'($urandom_range(0, (N + 4) * 4 - 1)), r);
                7: idle($urandom_range(0, 70));
                8: apb_read(KEY_A, r);
                default: begin
                    apb_read(LOCK_A, r);
                    if ($urandom_range(0, 4) == 0) apb_write(STAT_A, $urandom);
                end
            endcase
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
